// File: rtl/disparo_pc.sv
// rtl/disparo_pc.sv - PC shot generator over a loaded N x N battleship board
// Optional neighbour hunting after a hit is built when DISPARO_PC_CAZA_EN is defined.
module disparo_pc #(
    parameter int N            = 5,
    parameter int MAX_INTENTOS = 8,
    parameter int CELDAS_BARCO = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cargar,
    input  logic [N-1:0][N-1:0][31:0]  matrizEntrada,
    input  logic                       disparar,
    input  logic [3:0]                 filaRandom,
    input  logic [3:0]                 columnaRandom,
    output logic [N-1:0][N-1:0][31:0]  matrizSalida,
    output logic [3:0]                 filaDisparo,
    output logic [3:0]                 columnaDisparo,
    output logic                       disparoListo,
    output logic                       acierto,
    output logic [4:0]                 aciertosTotales,
    output logic                       ocupado,
    output logic                       juegoTerminado
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ELEGIR  = 2'd1;
    localparam logic [1:0] S_BARRIDO = 2'd2;
    localparam logic [1:0] S_APLICAR = 2'd3;
    localparam int IW = $clog2(MAX_INTENTOS + 1);

    logic [1:0]                r_estado;
    logic [N-1:0][N-1:0][31:0] r_matriz;
    logic [3:0]                r_fila;
    logic [3:0]                r_col;
    logic                      r_listo;
    logic                      r_acierto;
    logic [4:0]                r_aciertos;
    logic                      r_fin;
    logic [IW-1:0]             r_intentos;
    logic [3:0]                r_bf;
    logic [3:0]                r_bc;

    logic                      w_cand_ok;
    logic                      w_scan_ok;
    logic                      w_es_barco;
    logic [4:0]                w_nuevo;

    // Out-of-range coordinates read as water; callers check bounds separately.
    function automatic logic [31:0] leer(input logic [N-1:0][N-1:0][31:0] m,
                                         input logic [3:0] f, input logic [3:0] c);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (4'(i) == f && 4'(j) == c) v = m[i][j];
        return v;
    endfunction

    function automatic logic disparada(input logic [31:0] v);
        return (v == 32'd2) || (v == 32'd3);
    endfunction

    always_comb begin
        w_cand_ok  = (filaRandom < 4'(N)) && (columnaRandom < 4'(N)) &&
                     !disparada(leer(r_matriz, filaRandom, columnaRandom));
        w_scan_ok  = !disparada(leer(r_matriz, r_bf, r_bc));
        w_es_barco = leer(r_matriz, r_fila, r_col) != 32'd0;
        w_nuevo    = (r_aciertos < 5'(CELDAS_BARCO)) ? r_aciertos + 5'd1 : r_aciertos;
    end

`ifdef DISPARO_PC_CAZA_EN
    logic       r_caza_valid;
    logic [3:0] r_caza_f;
    logic [3:0] r_caza_c;
    logic       r_probando;
    logic [1:0] r_dir;
    logic [3:0] w_vec_f;
    logic [3:0] w_vec_c;
    logic       w_vec_ok;

    // Neighbour order up, right, down, left; underflow wraps to 15 and fails the bound check.
    always_comb begin
        w_vec_f = r_caza_f;
        w_vec_c = r_caza_c;
        case (r_dir)
            2'd0:    w_vec_f = r_caza_f - 4'd1;
            2'd1:    w_vec_c = r_caza_c + 4'd1;
            2'd2:    w_vec_f = r_caza_f + 4'd1;
            default: w_vec_c = r_caza_c - 4'd1;
        endcase
        w_vec_ok = (w_vec_f < 4'(N)) && (w_vec_c < 4'(N)) &&
                   !disparada(leer(r_matriz, w_vec_f, w_vec_c));
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado   <= S_IDLE;
            r_matriz   <= '0;
            r_fila     <= '0;
            r_col      <= '0;
            r_listo    <= 1'b0;
            r_acierto  <= 1'b0;
            r_aciertos <= '0;
            r_fin      <= 1'b0;
            r_intentos <= '0;
            r_bf       <= '0;
            r_bc       <= '0;
`ifdef DISPARO_PC_CAZA_EN
            r_caza_valid <= 1'b0;
            r_caza_f     <= '0;
            r_caza_c     <= '0;
            r_probando   <= 1'b0;
            r_dir        <= '0;
`endif
        end else begin
            r_listo <= 1'b0;
            if (cargar) begin
                // Loading also aborts any shot in flight without touching the board.
                r_matriz   <= matrizEntrada;
                r_aciertos <= '0;
                r_acierto  <= 1'b0;
                r_fin      <= 1'b0;
                r_estado   <= S_IDLE;
`ifdef DISPARO_PC_CAZA_EN
                r_caza_valid <= 1'b0;
                r_probando   <= 1'b0;
`endif
            end else begin
                case (r_estado)
                    S_IDLE: begin
                        if (disparar && !r_fin) begin
                            r_estado   <= S_ELEGIR;
                            r_intentos <= '0;
`ifdef DISPARO_PC_CAZA_EN
                            r_probando <= r_caza_valid;
                            r_dir      <= '0;
`endif
                        end
                    end
                    S_ELEGIR: begin
`ifdef DISPARO_PC_CAZA_EN
                        if (r_probando) begin
                            if (w_vec_ok) begin
                                r_fila     <= w_vec_f;
                                r_col      <= w_vec_c;
                                r_probando <= 1'b0;
                                r_estado   <= S_APLICAR;
                            end else begin
                                r_dir <= r_dir + 2'd1;
                                if (r_dir == 2'd3) r_probando <= 1'b0;
                            end
                        end else
`endif
                        if (w_cand_ok) begin
                            r_fila   <= filaRandom;
                            r_col    <= columnaRandom;
                            r_estado <= S_APLICAR;
                        end else begin
                            r_intentos <= r_intentos + IW'(1);
                            if (r_intentos == IW'(MAX_INTENTOS - 1)) begin
                                r_estado <= S_BARRIDO;
                                r_bf     <= '0;
                                r_bc     <= '0;
                            end
                        end
                    end
                    S_BARRIDO: begin
                        if (w_scan_ok) begin
                            r_fila   <= r_bf;
                            r_col    <= r_bc;
                            r_estado <= S_APLICAR;
                        end else if (r_bc == 4'(N - 1)) begin
                            r_bc <= '0;
                            r_bf <= (r_bf == 4'(N - 1)) ? 4'd0 : r_bf + 4'd1;
                        end else begin
                            r_bc <= r_bc + 4'd1;
                        end
                    end
                    S_APLICAR: begin
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                if (4'(i) == r_fila && 4'(j) == r_col)
                                    r_matriz[i][j] <= w_es_barco ? 32'd3 : 32'd2;
                        r_listo   <= 1'b1;
                        r_acierto <= w_es_barco;
                        if (w_es_barco) begin
                            r_aciertos <= w_nuevo;
                            if (w_nuevo == 5'(CELDAS_BARCO)) r_fin <= 1'b1;
                        end
`ifdef DISPARO_PC_CAZA_EN
                        r_caza_valid <= w_es_barco;
                        r_caza_f     <= r_fila;
                        r_caza_c     <= r_col;
`endif
                        r_estado <= S_IDLE;
                    end
                    default: r_estado <= S_IDLE;
                endcase
            end
        end
    end

    assign matrizSalida    = r_matriz;
    assign filaDisparo     = r_fila;
    assign columnaDisparo  = r_col;
    assign disparoListo    = r_listo;
    assign acierto         = r_acierto;
    assign aciertosTotales = r_aciertos;
    assign juegoTerminado  = r_fin;
    assign ocupado         = (r_estado != S_IDLE);

endmodule

// File: tb/tb_disparo_pc.sv
// tb/tb_disparo_pc.sv - table-driven bench for disparo_pc (default build)
module tb_disparo_pc;

    localparam int N = 5;
    typedef logic [N-1:0][N-1:0][31:0] tablero_t;

    typedef struct {
        logic [3:0]  f, c, f2, c2;
        int          lat;
        logic [3:0]  ef, ec;
        logic        ea;
        int          et;
        logic        efin;
        logic [31:0] ecell;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, cargar, disparar;
    tablero_t    matrizEntrada, matrizSalida;
    logic [3:0]  filaRandom, columnaRandom, filaDisparo, columnaDisparo;
    logic        disparoListo, acierto, ocupado, juegoTerminado;
    logic [4:0]  aciertosTotales;

    int n_pass = 0;
    int n_total = 0;
    tablero_t board, board3;
    vec_t tbl[$];

    disparo_pc #(.N(5), .MAX_INTENTOS(8), .CELDAS_BARCO(15)) dut (
        .clk(clk), .reset(reset), .cargar(cargar), .matrizEntrada(matrizEntrada),
        .disparar(disparar), .filaRandom(filaRandom), .columnaRandom(columnaRandom),
        .matrizSalida(matrizSalida), .filaDisparo(filaDisparo), .columnaDisparo(columnaDisparo),
        .disparoListo(disparoListo), .acierto(acierto), .aciertosTotales(aciertosTotales),
        .ocupado(ocupado), .juegoTerminado(juegoTerminado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic [31:0] celda(input tablero_t m, input logic [3:0] f, input logic [3:0] c);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (4'(i) == f && 4'(j) == c) v = m[i][j];
        return v;
    endfunction

    function automatic vec_t mk(input int f, input int c, input int f2, input int c2, input int lat,
                                input int ef, input int ec, input int ea, input int et,
                                input int efin, input int ecell);
        vec_t v;
        v.f = 4'(f); v.c = 4'(c); v.f2 = 4'(f2); v.c2 = 4'(c2); v.lat = lat;
        v.ef = 4'(ef); v.ec = 4'(ec); v.ea = ea[0]; v.et = et; v.efin = efin[0];
        v.ecell = 32'(ecell);
        return v;
    endfunction

    // One request; candidate switches to (f2,c2) after the first ELEGIR sample.
    task automatic disparo(input logic [3:0] f, input logic [3:0] c,
                           input logic [3:0] f2, input logic [3:0] c2, output int lat);
        @(negedge clk);
        filaRandom = f; columnaRandom = c; disparar = 1'b1;
        @(negedge clk);
        disparar = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin filaRandom = f2; columnaRandom = c2; end
            if (disparoListo) begin lat = i; break; end
        end
    endtask

    task automatic pulso_cargar(input tablero_t b);
        @(negedge clk);
        matrizEntrada = b; cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
    endtask

    initial begin
        int lat;
        int vistos;
        reset = 1'b1; cargar = 1'b0; disparar = 1'b0;
        filaRandom = '0; columnaRandom = '0; matrizEntrada = '0;

        board = '0;
        for (int j = 1; j < 5; j++) board[0][j] = 32'd4;
        for (int j = 0; j < 5; j++) board[2][j] = 32'd5;
        for (int j = 0; j < 3; j++) board[3][j] = 32'd6;
        board[4][0] = 32'd7; board[4][1] = 32'd7; board[4][3] = 32'd1;
        board3 = '0;
        for (int j = 0; j < 5; j++) begin board3[0][j] = 32'd2; board3[1][j] = 32'd3; end

        tbl.push_back(mk(2,3, 2,3,  2, 2,3, 1, 1, 0, 3));
        tbl.push_back(mk(0,0, 0,0,  2, 0,0, 0, 1, 0, 2));
        tbl.push_back(mk(7,9, 7,9, 11, 0,1, 1, 2, 0, 3));
        tbl.push_back(mk(2,3, 1,1,  3, 1,1, 0, 2, 0, 2));
        tbl.push_back(mk(0,2, 0,2,  2, 0,2, 1, 3, 0, 3));
        tbl.push_back(mk(0,3, 0,3,  2, 0,3, 1, 4, 0, 3));
        tbl.push_back(mk(0,4, 0,4,  2, 0,4, 1, 5, 0, 3));
        tbl.push_back(mk(2,0, 2,0,  2, 2,0, 1, 6, 0, 3));
        tbl.push_back(mk(2,1, 2,1,  2, 2,1, 1, 7, 0, 3));
        tbl.push_back(mk(2,2, 2,2,  2, 2,2, 1, 8, 0, 3));
        tbl.push_back(mk(2,4, 2,4,  2, 2,4, 1, 9, 0, 3));
        tbl.push_back(mk(3,0, 3,0,  2, 3,0, 1,10, 0, 3));
        tbl.push_back(mk(3,1, 3,1,  2, 3,1, 1,11, 0, 3));
        tbl.push_back(mk(3,2, 3,2,  2, 3,2, 1,12, 0, 3));
        tbl.push_back(mk(4,0, 4,0,  2, 4,0, 1,13, 0, 3));
        tbl.push_back(mk(4,1, 4,1,  2, 4,1, 1,14, 0, 3));
        tbl.push_back(mk(4,3, 4,3,  2, 4,3, 1,15, 1, 3));

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_matriz", 32'(matrizSalida == '0), 1);
        chk("rst_fila", 32'(filaDisparo), 0);
        chk("rst_col", 32'(columnaDisparo), 0);
        chk("rst_listo", 32'(disparoListo), 0);
        chk("rst_acierto", 32'(acierto), 0);
        chk("rst_total", 32'(aciertosTotales), 0);
        chk("rst_ocupado", 32'(ocupado), 0);
        chk("rst_fin", 32'(juegoTerminado), 0);

        pulso_cargar(board);
        chk("carga_matriz", 32'(matrizSalida == board), 1);

        foreach (tbl[k]) begin
            disparo(tbl[k].f, tbl[k].c, tbl[k].f2, tbl[k].c2, lat);
            chk($sformatf("v%0d_lat", k), 32'(lat), 32'(tbl[k].lat));
            chk($sformatf("v%0d_fila", k), 32'(filaDisparo), 32'(tbl[k].ef));
            chk($sformatf("v%0d_col", k), 32'(columnaDisparo), 32'(tbl[k].ec));
            chk($sformatf("v%0d_acierto", k), 32'(acierto), 32'(tbl[k].ea));
            chk($sformatf("v%0d_total", k), 32'(aciertosTotales), 32'(tbl[k].et));
            chk($sformatf("v%0d_fin", k), 32'(juegoTerminado), 32'(tbl[k].efin));
            chk($sformatf("v%0d_celda", k), celda(matrizSalida, tbl[k].ef, tbl[k].ec), tbl[k].ecell);
            if (k == 3) chk("v3_celda23", celda(matrizSalida, 4'd2, 4'd3), 3);
            @(negedge clk);
            chk($sformatf("v%0d_pulso", k), 32'(disparoListo), 0);
        end

        // Game over: further requests get no response.
        @(negedge clk);
        filaRandom = 4'd1; columnaRandom = 4'd2; disparar = 1'b1;
        @(negedge clk);
        disparar = 1'b0;
        vistos = 0;
        for (int i = 0; i < 12; i++) begin
            if (disparoListo || ocupado) vistos++;
            @(negedge clk);
        end
        chk("fin_sin_respuesta", 32'(vistos), 0);
        chk("fin_total_sat", 32'(aciertosTotales), 15);

        pulso_cargar(board);
        chk("recarga_fin", 32'(juegoTerminado), 0);
        chk("recarga_total", 32'(aciertosTotales), 0);
        chk("recarga_matriz", 32'(matrizSalida == board), 1);

        // cargar in the cycle after acceptance aborts the shot.
        @(negedge clk);
        filaRandom = 4'd0; columnaRandom = 4'd0; disparar = 1'b1;
        @(negedge clk);
        disparar = 1'b0; matrizEntrada = board3; cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        vistos = 0;
        for (int i = 0; i < 8; i++) begin
            if (disparoListo) vistos++;
            @(negedge clk);
        end
        chk("aborto_sin_listo", 32'(vistos), 0);
        chk("aborto_matriz", 32'(matrizSalida == board3), 1);
        chk("aborto_ocupado", 32'(ocupado), 0);

        // Reset while BARRIDO is still scanning the already-shot first rows.
        @(negedge clk);
        filaRandom = 4'd7; columnaRandom = 4'd9; disparar = 1'b1;
        @(negedge clk);
        disparar = 1'b0;
        repeat (12) @(negedge clk);
        chk("barrido_ocupado", 32'(ocupado), 1);
        chk("barrido_sin_listo", 32'(disparoListo), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_matriz", 32'(matrizSalida == '0), 1);
        chk("rst2_ocupado", 32'(ocupado), 0);
        chk("rst2_fila", 32'(filaDisparo), 0);
        chk("rst2_col", 32'(columnaDisparo), 0);
        chk("rst2_listo", 32'(disparoListo), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
